candidate_acc_array: RTL and testbench

- Parametrised successor to the single-counter candidate accumulator.
- Accumulates the popcount of a LANES-wide hit bus into one of CH per-channel candidate counters, selected per cycle.
- Pipelined popcount, saturating adds, sticky per-channel overflow flags.
- Sits between the lookup hit bus and the candidate-selection logic; after done_i, streams the final counts out over a valid/ready handshake.

---
 rtl/candidate_acc_array_pkg.sv | 31 +++
 rtl/candidate_acc_array_popcount.sv | 28 ++
 rtl/candidate_acc_array.sv | 198 +++++++++++++++++++
 tb/tb_candidate_acc_array.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/candidate_acc_array_pkg.sv
// ---------------------------------------------------------------------------
// candidate_acc_array_pkg
// Shared definitions for the candidate accumulator array and its helpers:
//   LU_BUS_SZ    - default lookup hit-bus width (lanes per cycle)
//   CANDIDATE_SZ - default candidate counter width in bits
//   acc_state_e  - readout controller states (idle / drain / output)
//   CAA_POPCNT_W - macro giving the popcount result width for n lanes
//   popcntWidth  - the same width as a constant function, for parameters
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef CAA_POPCNT_W
`define CAA_POPCNT_W(n) ($clog2((n) + 1))
`endif

package candidate_acc_array_pkg;

   localparam int LU_BUS_SZ    = 4;
   localparam int CANDIDATE_SZ = 8;

   typedef enum logic [1:0] {
      ACC_IDLE  = 2'd0,
      ACC_DRAIN = 2'd1,
      ACC_OUT   = 2'd2
   } acc_state_e;

   // Number of bits needed to hold a count of 0..lanes set bits.
   function automatic int popcntWidth(input int lanes);
      return `CAA_POPCNT_W(lanes);
   endfunction

endpackage

// File: rtl/candidate_acc_array_popcount.sv
// ---------------------------------------------------------------------------
// popcount_lanes
// Purely combinational population count of a LANES-wide bit vector.
// Ports:
//   i_bits  [LANES-1:0]  bits to count
//   o_count [PC_W-1:0]   number of set bits, PC_W = $clog2(LANES+1)
// ---------------------------------------------------------------------------
module popcount_lanes
   import candidate_acc_array_pkg::*;
#(
   parameter  int LANES = LU_BUS_SZ,
   localparam int PC_W  = popcntWidth(LANES)
) (
   input  logic [LANES-1:0] i_bits,
   output logic [PC_W-1:0]  o_count
);

   // Sum every lane as a PC_W-wide term; the sum can never exceed LANES,
   // so PC_W bits are always enough. Synthesis rebalances this chain of
   // adds into an adder tree.
   always_comb begin
      o_count = '0;
      for (int i = 0; i < LANES; i++) begin
         o_count = o_count + PC_W'(i_bits[i]);
      end
   end

endmodule

// File: rtl/candidate_acc_array.sv
// ---------------------------------------------------------------------------
// candidate_acc_array
// Accumulates the popcount of the masked lookup hit bus into one of CH
// saturating candidate counters (two-stage pipeline: popcount register, then
// add). Each counter carries a sticky overflow flag. A done_i pulse drains
// the pipeline and then streams all CH counts out over valid/ready.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   acc_en_i            accumulate hit_i into channel ch_sel_i this cycle
//   acc_clear_i         synchronous clear of counters, flags, pipeline, FSM
//   ch_sel_i            target channel (out-of-range values drop the beat)
//   hit_i, lane_mask_i  per-lane hit flags and lane enables
//   done_i              start readout (ignored while busy_o)
//   busy_o              high while draining or streaming out
//   cand_valid_o/cand_ready_i  readout handshake
//   cand_o, cand_ch_o, cand_ovf_o, cand_last_o  readout beat contents
// ---------------------------------------------------------------------------
module candidate_acc_array
   import candidate_acc_array_pkg::*;
#(
   parameter  int LANES       = LU_BUS_SZ,
   parameter  int CH          = 4,
   parameter  int CNT_W       = CANDIDATE_SZ,
   parameter  bit CLR_ON_READ = 1'b1,
   localparam int CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             acc_en_i,
   input  logic             acc_clear_i,
   input  logic [CH_W-1:0]  ch_sel_i,
   input  logic [LANES-1:0] hit_i,
   input  logic [LANES-1:0] lane_mask_i,
   input  logic             done_i,
   output logic             busy_o,
   output logic             cand_valid_o,
   input  logic             cand_ready_i,
   output logic [CNT_W-1:0] cand_o,
   output logic [CH_W-1:0]  cand_ch_o,
   output logic             cand_ovf_o,
   output logic             cand_last_o
);

   localparam int                PC_W    = popcntWidth(LANES);
   localparam int                SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0]  CNT_MAX = SUM_W'({CNT_W{1'b1}});
   localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CH - 1);

   acc_state_e        r_state;
   logic              r_drainCnt;
   logic [CH_W-1:0]   r_chIdx;
   logic              r_busy;
   logic              r_candValid;
   logic              r_candLast;

   logic              r_p1Vld;
   logic [PC_W-1:0]   r_p1Cnt;
   logic [CH_W-1:0]   r_p1Ch;

   logic [CNT_W-1:0]  r_cnt [CH];
   logic [CH-1:0]     r_ovf;

   logic [PC_W-1:0]   w_hitCount;
   logic              w_chOk;
   logic              w_accept;
   logic              w_handshake;
   logic              w_readDone;
   logic [SUM_W-1:0]  w_sum;
   logic              w_sat;
   logic [CH_W-1:0]   w_nextCh;

   popcount_lanes #(
      .LANES (LANES)
   ) u_popcount (
      .i_bits  (hit_i & lane_mask_i),
      .o_count (w_hitCount)
   );

   assign w_chOk      = (32'(ch_sel_i) < CH);
   assign w_accept    = acc_en_i && !r_busy && !acc_clear_i && w_chOk;
   assign w_handshake = r_candValid && cand_ready_i;
   assign w_readDone  = w_handshake && r_candLast;
   assign w_nextCh    = r_chIdx + 1'b1;

   // The stage-2 adder always reads the live counter, so consecutive hits on
   // the same channel chain correctly without any forwarding or stall.
   assign w_sum = SUM_W'(r_cnt[r_p1Ch]) + SUM_W'(r_p1Cnt);
   assign w_sat = (w_sum > CNT_MAX);

   // Stage 1: capture the masked popcount and its channel. Beats arriving
   // while busy, during a clear, or aimed at a nonexistent channel are
   // simply not marked valid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_p1Vld <= 1'b0;
         r_p1Cnt <= '0;
         r_p1Ch  <= '0;
      end else begin
         r_p1Vld <= w_accept;
         if (w_accept) begin
            r_p1Cnt <= w_hitCount;
            r_p1Ch  <= ch_sel_i;
         end
      end
   end

   // Stage 2: saturating add into the selected counter. A clear (explicit or
   // after a complete readout) wins over any update still in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < CH; c++) begin
            r_cnt[c] <= '0;
         end
         r_ovf <= '0;
      end else if (acc_clear_i || (CLR_ON_READ && w_readDone)) begin
         for (int c = 0; c < CH; c++) begin
            r_cnt[c] <= '0;
         end
         r_ovf <= '0;
      end else if (r_p1Vld) begin
         r_cnt[r_p1Ch] <= w_sat ? CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
         if (w_sat) begin
            r_ovf[r_p1Ch] <= 1'b1;
         end
      end
   end

   // Readout controller. DRAIN waits two cycles so the last accepted beat
   // (possibly the one sampled together with done_i) has landed before the
   // first count goes out. Beat flags are registered here; the count and
   // flag of the current channel are muxed straight from the counters,
   // which cannot change while busy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ACC_IDLE;
         r_drainCnt  <= 1'b0;
         r_chIdx     <= '0;
         r_busy      <= 1'b0;
         r_candValid <= 1'b0;
         r_candLast  <= 1'b0;
      end else if (acc_clear_i) begin
         r_state     <= ACC_IDLE;
         r_drainCnt  <= 1'b0;
         r_chIdx     <= '0;
         r_busy      <= 1'b0;
         r_candValid <= 1'b0;
         r_candLast  <= 1'b0;
      end else begin
         case (r_state)
            ACC_IDLE: begin
               if (done_i) begin
                  r_state    <= ACC_DRAIN;
                  r_drainCnt <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ACC_DRAIN: begin
               if (r_drainCnt) begin
                  r_state     <= ACC_OUT;
                  r_chIdx     <= '0;
                  r_candValid <= 1'b1;
                  r_candLast  <= (CH == 1);
               end else begin
                  r_drainCnt <= 1'b1;
               end
            end
            ACC_OUT: begin
               if (w_handshake) begin
                  if (r_candLast) begin
                     r_state     <= ACC_IDLE;
                     r_chIdx     <= '0;
                     r_busy      <= 1'b0;
                     r_candValid <= 1'b0;
                     r_candLast  <= 1'b0;
                  end else begin
                     r_chIdx    <= w_nextCh;
                     r_candLast <= (w_nextCh == LAST_CH);
                  end
               end
            end
            default: begin
               r_state     <= ACC_IDLE;
               r_busy      <= 1'b0;
               r_candValid <= 1'b0;
               r_candLast  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o       = r_busy;
   assign cand_valid_o = r_candValid;
   assign cand_ch_o    = r_chIdx;
   assign cand_last_o  = r_candLast;
   assign cand_o       = r_candValid ? r_cnt[r_chIdx] : '0;
   assign cand_ovf_o   = r_candValid & r_ovf[r_chIdx];

endmodule

// File: tb/tb_candidate_acc_array.sv
// ---------------------------------------------------------------------------
// tb_candidate_acc_array
// Drives two instances of candidate_acc_array from the same stimulus: u_dut
// clears its counts after each full readout, u_dutKeep retains them. Counts
// are predicted by a plain per-channel integer model with saturation.
// ---------------------------------------------------------------------------
module tb_candidate_acc_array;

   localparam int CH      = 4;
   localparam int LANES   = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = 255;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             acc_en_i;
   logic             acc_clear_i;
   logic [1:0]       ch_sel_i;
   logic [LANES-1:0] hit_i;
   logic [LANES-1:0] lane_mask_i;
   logic             done_i;
   logic             cand_ready_i;

   logic             busy_o, cand_valid_o, cand_ovf_o, cand_last_o;
   logic [CNT_W-1:0] cand_o;
   logic [1:0]       cand_ch_o;
   logic             busyK, validK, ovfK, lastK;
   logic [CNT_W-1:0] candK;
   logic [1:0]       chK;

   int nChecks = 0;
   int nFail   = 0;
   int mA [CH];
   int mB [CH];
   bit oA [CH];
   bit oB [CH];

   always #5 clk_i = ~clk_i;

   candidate_acc_array #(
      .LANES(LANES), .CH(CH), .CNT_W(CNT_W), .CLR_ON_READ(1'b1)
   ) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .acc_en_i(acc_en_i), .acc_clear_i(acc_clear_i),
      .ch_sel_i(ch_sel_i), .hit_i(hit_i), .lane_mask_i(lane_mask_i), .done_i(done_i),
      .busy_o(busy_o), .cand_valid_o(cand_valid_o), .cand_ready_i(cand_ready_i),
      .cand_o(cand_o), .cand_ch_o(cand_ch_o), .cand_ovf_o(cand_ovf_o),
      .cand_last_o(cand_last_o)
   );

   candidate_acc_array #(
      .LANES(LANES), .CH(CH), .CNT_W(CNT_W), .CLR_ON_READ(1'b0)
   ) u_dutKeep (
      .clk_i(clk_i), .rst_i(rst_i), .acc_en_i(acc_en_i), .acc_clear_i(acc_clear_i),
      .ch_sel_i(ch_sel_i), .hit_i(hit_i), .lane_mask_i(lane_mask_i), .done_i(done_i),
      .busy_o(busyK), .cand_valid_o(validK), .cand_ready_i(cand_ready_i),
      .cand_o(candK), .cand_ch_o(chK), .cand_ovf_o(ovfK),
      .cand_last_o(lastK)
   );

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic resetModels();
      for (int c = 0; c < CH; c++) begin
         mA[c] = 0; mB[c] = 0; oA[c] = 1'b0; oB[c] = 1'b0;
      end
   endtask

   // Reference behaviour: add the number of counted hits, clamp at the
   // counter maximum and remember that the clamp happened.
   task automatic modelAcc(input logic [1:0] ch, input logic [3:0] hit,
                           input logic [3:0] mask);
      int pc;
      pc = $countones(hit & mask);
      if (int'(ch) < CH) begin
         mA[ch] = mA[ch] + pc;
         mB[ch] = mB[ch] + pc;
         if (mA[ch] > CNT_MAX) begin mA[ch] = CNT_MAX; oA[ch] = 1'b1; end
         if (mB[ch] > CNT_MAX) begin mB[ch] = CNT_MAX; oB[ch] = 1'b1; end
      end
   endtask

   // One clock cycle of stimulus, presented 1 ns after an edge and released
   // 1 ns after the following edge.
   task automatic applyStimulus(input bit en, input bit clr, input logic [1:0] ch,
                                input logic [3:0] hit, input logic [3:0] mask,
                                input bit done);
      acc_en_i    = en;
      acc_clear_i = clr;
      ch_sel_i    = ch;
      hit_i       = hit;
      lane_mask_i = mask;
      done_i      = done;
      if (clr) resetModels();
      else if (en) modelAcc(ch, hit, mask);
      @(posedge clk_i); #1;
      acc_en_i    = 1'b0;
      acc_clear_i = 1'b0;
      done_i      = 1'b0;
   endtask

   task automatic waitValid(output int cycles);
      cycles = 0;
      while (cand_valid_o !== 1'b1 && cycles < 8) begin
         @(posedge clk_i); #1;
         cycles++;
      end
   endtask

   task automatic checkBeat(input int b);
      checkOutput("beat_valid",  cand_valid_o, 1);
      checkOutput("beat_busy",   busy_o, 1);
      checkOutput("beat_ch",     cand_ch_o, b);
      checkOutput("beat_count",  cand_o, mA[b]);
      checkOutput("beat_ovf",    cand_ovf_o, oA[b]);
      checkOutput("beat_last",   cand_last_o, (b == CH - 1));
      checkOutput("keep_valid",  validK, 1);
      checkOutput("keep_ch",     chK, b);
      checkOutput("keep_count",  candK, mB[b]);
      checkOutput("keep_ovf",    ovfK, oB[b]);
      checkOutput("keep_last",   lastK, (b == CH - 1));
   endtask

   // Pulse done_i (optionally with a last accumulate beat), then collect all
   // CH beats, holding ready low for a while before each one.
   task automatic doReadout(input int holdFirst, input bit enD, input logic [1:0] ch,
                            input logic [3:0] hit, input logic [3:0] mask);
      int cycles;
      int hold;
      applyStimulus(enD, 1'b0, ch, hit, mask, 1'b1);
      checkOutput("busy_after_done", busy_o, 1);
      waitValid(cycles);
      checkOutput("drain_cycles", cycles, 2);
      if (cand_valid_o !== 1'b1) return;
      for (int b = 0; b < CH; b++) begin
         hold = (b == 0) ? holdFirst : int'($urandom_range(0, 2));
         cand_ready_i = 1'b0;
         checkBeat(b);
         for (int h = 0; h < hold; h++) begin
            @(posedge clk_i); #1;
            checkBeat(b);
         end
         cand_ready_i = 1'b1;
         @(posedge clk_i); #1;
         cand_ready_i = 1'b0;
      end
      checkOutput("valid_after_last", cand_valid_o, 0);
      checkOutput("busy_after_last",  busy_o, 0);
      checkOutput("keep_valid_after", validK, 0);
      for (int c = 0; c < CH; c++) begin
         mA[c] = 0; oA[c] = 1'b0;
      end
   endtask

   initial begin
      int cycles;
      int n;
      resetModels();
      rst_i = 1'b1; acc_en_i = 1'b0; acc_clear_i = 1'b0; ch_sel_i = '0;
      hit_i = '0; lane_mask_i = '0; done_i = 1'b0; cand_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rst_busy",  busy_o, 0);
      checkOutput("rst_valid", cand_valid_o, 0);
      checkOutput("rst_cand",  cand_o, 0);
      checkOutput("rst_ch",    cand_ch_o, 0);
      checkOutput("rst_ovf",   cand_ovf_o, 0);
      checkOutput("rst_last",  cand_last_o, 0);
      checkOutput("rst_keep_valid", validK, 0);
      rst_i = 1'b0;

      $display("[TB] basic accumulate");
      repeat (3) applyStimulus(1'b1, 1'b0, 2'd2, 4'b1011, 4'hF, 1'b0);
      doReadout(0, 1'b0, 2'd0, 4'h0, 4'h0);

      $display("[TB] latency and masking");
      applyStimulus(1'b1, 1'b0, 2'd1, 4'hF, 4'b0101, 1'b0);
      checkOutput("lat_edge1", u_dut.r_cnt[1], 0);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
      checkOutput("lat_edge2", u_dut.r_cnt[1], 2);
      repeat (3) applyStimulus(1'b1, 1'b0, 2'd3, 4'hF, 4'hF, 1'b0);
      doReadout(0, 1'b0, 2'd0, 4'h0, 4'h0);

      $display("[TB] saturation with backpressure");
      repeat (63) applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'd0, 4'b0011, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
      checkOutput("sat_value", u_dut.r_cnt[0], 255);
      checkOutput("sat_flag",  u_dut.r_ovf[0], 1);
      doReadout(5, 1'b1, 2'd0, 4'hF, 4'hF);

      $display("[TB] randomized rounds");
      for (int r = 0; r < 4; r++) begin
         n = 20 + int'($urandom_range(0, 20));
         for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 2'($urandom),
                          4'($urandom), 4'($urandom), 1'b0);
         end
         doReadout(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   2'($urandom), 4'($urandom), 4'($urandom));
      end
      doReadout(1, 1'b0, 2'd0, 4'h0, 4'h0);

      $display("[TB] clear priority");
      applyStimulus(1'b1, 1'b0, 2'd2, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b1, 2'd3, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
      checkOutput("clr_inflight_ch2", u_dutKeep.r_cnt[2], 0);
      checkOutput("clr_same_cycle_ch3", u_dutKeep.r_cnt[3], 0);
      doReadout(0, 1'b0, 2'd0, 4'h0, 4'h0);

      applyStimulus(1'b1, 1'b0, 2'd1, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
      waitValid(cycles);
      checkOutput("clr_out_valid_pre", cand_valid_o, 1);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0);
      checkOutput("clr_out_valid", cand_valid_o, 0);
      checkOutput("clr_out_busy",  busy_o, 0);
      checkOutput("clr_out_keep_valid", validK, 0);
      doReadout(0, 1'b0, 2'd0, 4'h0, 4'h0);

      $display("[TB] asynchronous reset during readout");
      repeat (2) applyStimulus(1'b1, 1'b0, 2'd3, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
      waitValid(cycles);
      checkOutput("rstmid_valid_pre", cand_valid_o, 1);
      cand_ready_i = 1'b0;
      #1 rst_i = 1'b1;
      #1;
      checkOutput("rstmid_valid", cand_valid_o, 0);
      checkOutput("rstmid_busy",  busy_o, 0);
      checkOutput("rstmid_keep_valid", validK, 0);
      checkOutput("rstmid_keep_busy",  busyK, 0);
      resetModels();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      doReadout(0, 1'b0, 2'd0, 4'h0, 4'h0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b0, 2'($urandom), 4'($urandom), 4'hF, 1'b0);
      end
      doReadout(2, 1'b0, 2'd0, 4'h0, 4'h0);
      doReadout(0, 1'b0, 2'd0, 4'h0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
